md_issue_writeback: RTL and testbench
=====================================

Name: md_issue_writeback

Overview:
Pipeline-side counterpart of the multi-cycle multiply/divide wrapper. Issues mul/div start pulses from DX and tracks the one in-flight operation. Stalls F/D on structural, RAW and WAW hazards against the pending destination. Arbitrates the single register-file write port between normal MW writeback and the returning mul/div result (or the rstatus exception write).

Parameters:
RSTATUS_REG, 30, register written on mul/div exception
MUL_EXC_CODE, 4, value written to RSTATUS_REG on mul overflow
DIV_EXC_CODE, 5, value written to RSTATUS_REG on divide-by-zero

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
isMul_dx  input  1  DX instruction is mul
isDiv_dx  input  1  DX instruction is div
rs_dx  input  5  DX source reg A
rt_dx  input  5  DX source reg B
rd_dx  input  5  DX destination reg
we_dx  input  1  DX instruction writes rd_dx (non-md)
MD_result  input  32  result from mul/div unit
MD_exception  input  1  mul/div exception, valid with MD_resultRDY
MD_resultRDY  input  1  one-cycle completion pulse
ctrl_writeReg_mdc  input  5  destination latched by mul/div unit
wb_we  input  1  MW stage normal write enable
wb_reg  input  5  MW stage destination
wb_data  input  32  MW stage write data
md_start_mul  output  1  start pulse to unit isMul
md_start_div  output  1  start pulse to unit isDiv
stall_fd  output  1  freeze PC/FD, bubble into DX
md_busy  output  1  operation in flight or result pending
ctrl_writeEnable  output  1  regfile write enable
ctrl_writeReg  output  5  regfile write address
data_writeReg  output  32  regfile write data

Behaviour:
- Reset: state IDLE; pend_rd, pend_exc, pend_isdiv, buf_data cleared; all outputs 0. Reset mid-operation drops the in-flight op with no write; the mul/div unit shares the reset.
- States: IDLE, BUSY, PEND (2-bit register).
- IDLE: on isMul_dx or isDiv_dx, md_start_mul/div = isMul_dx/isDiv_dx combinationally in the same cycle, no stall. Latch pend_rd=rd_dx and pend_isdiv=isDiv_dx. Next state BUSY. Both inputs high is illegal and is treated as mul.
- BUSY, no MD_resultRDY: md_busy=1, start outputs 0.
- BUSY with MD_resultRDY:
  - wb_we=0: write the result this cycle, next state IDLE.
  - wb_we=1: capture MD_result/MD_exception into buf, next state PEND.
- PEND: write buf when wb_we=0, then go IDLE. Normal writeback always has priority.
- Write contents (result or buffered):
  - Exception: ctrl_writeReg=RSTATUS_REG; data = DIV_EXC_CODE if pend_isdiv, else MUL_EXC_CODE.
  - No exception: ctrl_writeReg=pend_rd, data=MD_result/buf.
  - pend_rd=0 with no exception: ctrl_writeEnable=0 and no write, but the state still advances.
- When no md write occurs, the port passes wb_we/wb_reg/wb_data through unchanged.
- stall_fd=1 when state is BUSY or PEND and any of the following holds:
  - (isMul_dx|isDiv_dx): structural hazard.
  - pend_rd!=0 and (rs_dx==pend_rd or rt_dx==pend_rd): RAW hazard.
  - we_dx and rd_dx==pend_rd: WAW hazard.
  - any DX source or dest == RSTATUS_REG: exception hazard.
- The stall is combinational from the current state. MD_resultRDY in the same cycle does not release the stall; release takes effect the cycle after the write.
- A stalled mul/div issues from IDLE in the cycle after completion: back-to-back gap is 1 cycle.
- Progress guarantee: stall_fd drains MW within 3 cycles, so PEND always resolves.
- md_busy = (state != IDLE).

Decomposition:
- Shared package: state encodings, RSTATUS_REG and the exception codes (also used by the ALU overflow path), 5-bit register-index width.
- One natural sub-module: md_hazard_detect, the combinational stall_fd comparator.

Test Plan:
- mul rd=5 issued, no wb traffic, unit returns 0x00000030 -> start pulse 1 cycle; write r5=0x30 on the RDY cycle; md_busy falls the next cycle.
- Dependent add reading r5 in DX during BUSY -> stall_fd=1 until the cycle after the write; independent add using r6/r7 -> no stall.
- RDY coincides with wb_we=1 (r8=0x11) -> r8 written first; next free cycle writes r5 from buf; state passes through PEND.
- div with MD_exception=1 -> r30=5 written, r(rd) untouched; mul exception -> r30=4.
- Second mul in DX while BUSY -> stalled, no start pulse; issues the cycle after the first result is written.
- reset asserted mid-BUSY -> next cycle IDLE, all outputs 0, no write; mul rd=0 completing -> ctrl_writeEnable stays 0.

Source files
------------

// File: rtl/md_issue_writeback_pkg.sv
// Shared definitions for the mul/div issue and writeback block: state encoding,
// register-index width and the exception-status constants.
package md_issue_writeback_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_PEND = 2'd2
    } md_state_t;

    // Shared with the ALU overflow path, which writes the same status register.
    localparam logic [REG_W-1:0] RSTATUS_REG  = 5'd30;
    localparam logic [31:0]      MUL_EXC_CODE = 32'd4;
    localparam logic [31:0]      DIV_EXC_CODE = 32'd5;

endpackage

// File: rtl/md_issue_writeback_hazard_detect.sv
// Combinational F/D stall decision against the single pending mul/div destination.
module md_hazard_detect #(
    parameter logic [4:0] RSTATUS_REG = md_issue_writeback_pkg::RSTATUS_REG
) (
    input  logic       active,
    input  logic       is_mul,
    input  logic       is_div,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    input  logic       we,
    input  logic [4:0] pend_rd,
    output logic       stall
);
    logic structural;
    logic raw;
    logic waw;
    logic status_hz;

    assign structural = is_mul | is_div;
    assign raw        = (pend_rd != 5'd0) && ((rs == pend_rd) || (rt == pend_rd));
    assign waw        = we && (rd == pend_rd);
    // An exception may rewrite the status register, so any reference to it waits.
    assign status_hz  = (rs == RSTATUS_REG) || (rt == RSTATUS_REG) || (rd == RSTATUS_REG);

    assign stall = active && (structural || raw || waw || status_hz);

endmodule

// File: rtl/md_issue_writeback.sv
// Issues mul/div start pulses, tracks the one in-flight operation, stalls F/D on
// hazards and arbitrates the register-file write port with normal MW writeback.
module md_issue_writeback #(
    parameter logic [4:0]  RSTATUS_REG  = md_issue_writeback_pkg::RSTATUS_REG,
    parameter logic [31:0] MUL_EXC_CODE = md_issue_writeback_pkg::MUL_EXC_CODE,
    parameter logic [31:0] DIV_EXC_CODE = md_issue_writeback_pkg::DIV_EXC_CODE
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             isMul_dx,
    input  logic                             isDiv_dx,
    input  logic [4:0]                       rs_dx,
    input  logic [4:0]                       rt_dx,
    input  logic [4:0]                       rd_dx,
    input  logic                             we_dx,
    input  logic [31:0]                      MD_result,
    input  logic                             MD_exception,
    input  logic                             MD_resultRDY,
    input  logic [4:0]                       ctrl_writeReg_mdc,
    input  logic                             wb_we,
    input  logic [4:0]                       wb_reg,
    input  logic [31:0]                      wb_data,
    output logic                             md_start_mul,
    output logic                             md_start_div,
    output logic                             stall_fd,
    output logic                             md_busy,
    output logic                             ctrl_writeEnable,
    output logic [4:0]                       ctrl_writeReg,
    output logic [31:0]                      data_writeReg,
    output md_issue_writeback_pkg::md_state_t dbg_state
);
    import md_issue_writeback_pkg::*;

    md_state_t   state_q;
    md_state_t   state_d;
    logic [4:0]  pend_rd;
    logic        pend_isdiv;
    logic        pend_exc;
    logic [31:0] buf_data;

    logic        is_idle;
    logic        issue;
    logic        res_avail;
    logic        res_exc;
    logic [31:0] res_data;
    logic        md_write;
    logic        hazard_stall;

    // The unit's own latched destination duplicates pend_rd; kept on the port only.
    logic unused_mdc;
    assign unused_mdc = ^ctrl_writeReg_mdc;

    assign is_idle   = (state_q == ST_IDLE);
    assign issue     = is_idle && (isMul_dx || isDiv_dx);
    assign res_avail = ((state_q == ST_BUSY) && MD_resultRDY) || (state_q == ST_PEND);
    assign res_exc   = (state_q == ST_PEND) ? pend_exc : MD_exception;
    assign res_data  = (state_q == ST_PEND) ? buf_data : MD_result;
    assign md_write  = res_avail && !wb_we;
    assign dbg_state = state_q;

    md_hazard_detect #(
        .RSTATUS_REG (RSTATUS_REG)
    ) u_hazard (
        .active  (!is_idle),
        .is_mul  (isMul_dx),
        .is_div  (isDiv_dx),
        .rs      (rs_dx),
        .rt      (rt_dx),
        .rd      (rd_dx),
        .we      (we_dx),
        .pend_rd (pend_rd),
        .stall   (hazard_stall)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (issue) state_d = ST_BUSY;
            ST_BUSY: if (MD_resultRDY) state_d = wb_we ? ST_PEND : ST_IDLE;
            ST_PEND: if (!wb_we) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pend_rd    <= 5'd0;
            pend_isdiv <= 1'b0;
            pend_exc   <= 1'b0;
            buf_data   <= 32'd0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                pend_rd    <= rd_dx;
                pend_isdiv <= isDiv_dx && !isMul_dx;
            end
            if ((state_q == ST_BUSY) && MD_resultRDY && wb_we) begin
                buf_data <= MD_result;
                pend_exc <= MD_exception;
            end
        end
    end

    // Normal writeback owns the port whenever it is writing; md results wait.
    always_comb begin
        md_start_mul     = 1'b0;
        md_start_div     = 1'b0;
        stall_fd         = 1'b0;
        md_busy          = 1'b0;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = 5'd0;
        data_writeReg    = 32'd0;
        if (!reset) begin
            md_start_mul = is_idle && isMul_dx;
            md_start_div = is_idle && isDiv_dx && !isMul_dx;
            stall_fd     = hazard_stall;
            md_busy      = !is_idle;
            if (md_write) begin
                if (res_exc) begin
                    ctrl_writeEnable = 1'b1;
                    ctrl_writeReg    = RSTATUS_REG;
                    data_writeReg    = pend_isdiv ? DIV_EXC_CODE : MUL_EXC_CODE;
                end else if (pend_rd != 5'd0) begin
                    ctrl_writeEnable = 1'b1;
                    ctrl_writeReg    = pend_rd;
                    data_writeReg    = res_data;
                end
            end else begin
                ctrl_writeEnable = wb_we;
                ctrl_writeReg    = wb_reg;
                data_writeReg    = wb_data;
            end
        end
    end

endmodule

// File: tb/tb_md_issue_writeback.sv
// Directed test-plan scenarios followed by randomized traffic, all checked
// against a behavioural model of the issue/writeback rules.
module tb_md_issue_writeback;
    import md_issue_writeback_pkg::*;

    logic        clock;
    logic        reset;
    logic        isMul_dx, isDiv_dx, we_dx;
    logic [4:0]  rs_dx, rt_dx, rd_dx;
    logic [31:0] MD_result;
    logic        MD_exception, MD_resultRDY;
    logic [4:0]  ctrl_writeReg_mdc;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        md_start_mul, md_start_div, stall_fd, md_busy, ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    md_state_t   dbg_state;

    md_issue_writeback dut (
        .clock             (clock),
        .reset             (reset),
        .isMul_dx          (isMul_dx),
        .isDiv_dx          (isDiv_dx),
        .rs_dx             (rs_dx),
        .rt_dx             (rt_dx),
        .rd_dx             (rd_dx),
        .we_dx             (we_dx),
        .MD_result         (MD_result),
        .MD_exception      (MD_exception),
        .MD_resultRDY      (MD_resultRDY),
        .ctrl_writeReg_mdc (ctrl_writeReg_mdc),
        .wb_we             (wb_we),
        .wb_reg            (wb_reg),
        .wb_data           (wb_data),
        .md_start_mul      (md_start_mul),
        .md_start_div      (md_start_div),
        .stall_fd          (stall_fd),
        .md_busy           (md_busy),
        .ctrl_writeEnable  (ctrl_writeEnable),
        .ctrl_writeReg     (ctrl_writeReg),
        .data_writeReg     (data_writeReg),
        .dbg_state         (dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: an operation is either waiting on the unit or holding a
    // finished result that lost the write port to normal writeback.
    bit          m_waiting, m_holding, m_isdiv, m_hexc;
    logic [4:0]  m_rd;
    logic [31:0] m_hdata;
    bit          last_stall;

    // Emulated mul/div unit for the random phase.
    bit u_act;
    int u_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        isMul_dx = 0; isDiv_dx = 0; we_dx = 0;
        rs_dx = 0; rt_dx = 0; rd_dx = 0;
        MD_result = 0; MD_exception = 0; MD_resultRDY = 0;
        ctrl_writeReg_mdc = m_rd;
        wb_we = 0; wb_reg = 0; wb_data = 0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit          busy, have, rexc, do_md;
        logic [31:0] rdata;
        bit          e_stall, e_we;
        logic [4:0]  e_reg;
        logic [31:0] e_data;
        bit          check_port;
        md_state_t   e_state;
        @(negedge clock);
        busy    = m_waiting || m_holding;
        have    = (m_waiting && MD_resultRDY) || m_holding;
        rexc    = m_holding ? m_hexc : MD_exception;
        rdata   = m_holding ? m_hdata : MD_result;
        do_md   = have && !wb_we;
        e_stall = busy && (isMul_dx || isDiv_dx
                  || (m_rd != 0 && (rs_dx == m_rd || rt_dx == m_rd))
                  || (we_dx && rd_dx == m_rd)
                  || rs_dx == 5'd30 || rt_dx == 5'd30 || rd_dx == 5'd30);
        check_port = 1;
        if (do_md && rexc) begin
            e_we = 1; e_reg = 5'd30; e_data = m_isdiv ? 32'd5 : 32'd4;
        end else if (do_md && m_rd != 0) begin
            e_we = 1; e_reg = m_rd; e_data = rdata;
        end else if (do_md) begin
            e_we = 0; e_reg = 0; e_data = 0; check_port = 0;
        end else begin
            e_we = wb_we; e_reg = wb_reg; e_data = wb_data;
        end
        e_state = m_holding ? ST_PEND : (m_waiting ? ST_BUSY : ST_IDLE);
        if (reset) begin
            e_stall = 0; e_we = 0; e_reg = 0; e_data = 0; busy = 0; check_port = 1;
        end
        chk("start_mul", md_start_mul, !reset && !busy && isMul_dx);
        chk("start_div", md_start_div, !reset && !busy && isDiv_dx && !isMul_dx);
        chk("stall_fd", stall_fd, e_stall);
        chk("md_busy", md_busy, busy);
        chk("write_en", ctrl_writeEnable, e_we);
        if (check_port) begin
            chk("write_reg", ctrl_writeReg, e_reg);
            chk("write_data", data_writeReg, e_data);
        end
        chk("state", dbg_state, e_state);
        last_stall = e_stall;
        @(posedge clock);
        if (reset) begin
            m_waiting = 0; m_holding = 0; m_isdiv = 0; m_hexc = 0; m_rd = 0; m_hdata = 0;
            u_act = 0;
        end else begin
            if (u_act) begin
                if (MD_resultRDY) u_act = 0;
                else if (u_cnt > 0) u_cnt--;
            end
            if (do_md) begin
                m_waiting = 0; m_holding = 0;
            end else if (m_waiting && MD_resultRDY) begin
                m_waiting = 0; m_holding = 1; m_hdata = MD_result; m_hexc = MD_exception;
            end else if (!busy && (isMul_dx || isDiv_dx)) begin
                m_waiting = 1; m_rd = rd_dx; m_isdiv = isDiv_dx && !isMul_dx;
                u_act = 1; u_cnt = $urandom_range(0, 4);
            end
        end
        #1;
    endtask

    function automatic logic [4:0] rnd_reg();
        int v;
        v = $urandom_range(0, 9);
        return (v == 9) ? 5'd30 : 5'(v);
    endfunction

    initial begin
        m_rd = 0;
        clr_in();
        reset = 1;
        #1;
        cycle(); cycle();
        reset = 0;

        // mul r5, independent and dependent adds, result 0x30
        isMul_dx = 1; rd_dx = 5; rs_dx = 1; rt_dx = 2; cycle();
        clr_in(); we_dx = 1; rs_dx = 5; rt_dx = 6; rd_dx = 9; cycle();
        rs_dx = 6; rt_dx = 7; rd_dx = 8; cycle();
        rs_dx = 5; MD_resultRDY = 1; MD_result = 32'h30; cycle();
        MD_resultRDY = 0; cycle();
        clr_in(); cycle();

        // result collides with normal writeback and is held
        isMul_dx = 1; rd_dx = 5; cycle();
        clr_in(); MD_resultRDY = 1; MD_result = 32'h55;
        wb_we = 1; wb_reg = 8; wb_data = 32'h11; cycle();
        clr_in(); wb_we = 1; wb_reg = 9; wb_data = 32'h22; cycle();
        clr_in(); cycle();
        cycle();

        // div and mul exceptions
        isDiv_dx = 1; rd_dx = 12; cycle();
        clr_in(); MD_resultRDY = 1; MD_exception = 1; MD_result = 32'hdead; cycle();
        clr_in(); isMul_dx = 1; rd_dx = 13; cycle();
        clr_in(); MD_resultRDY = 1; MD_exception = 1; cycle();
        clr_in(); cycle();

        // second mul waits for the first to write back
        isMul_dx = 1; rd_dx = 3; cycle();
        rd_dx = 4; cycle();
        MD_resultRDY = 1; MD_result = 32'h333; cycle();
        MD_resultRDY = 0; cycle();
        clr_in(); MD_resultRDY = 1; MD_result = 32'h444; cycle();
        clr_in(); cycle();

        // reset mid-operation, then mul to r0
        isMul_dx = 1; rd_dx = 6; cycle();
        clr_in(); reset = 1; cycle();
        reset = 0; cycle();
        isMul_dx = 1; rd_dx = 0; cycle();
        clr_in(); MD_resultRDY = 1; MD_result = 32'hff; cycle();
        clr_in(); cycle();

        // randomized traffic; a stalled DX instruction is held in place
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!last_stall) begin
                isMul_dx = ($urandom_range(0, 5) == 0);
                isDiv_dx = ($urandom_range(0, 5) == 0);
                we_dx    = ($urandom_range(0, 1) == 1);
                rs_dx    = rnd_reg();
                rt_dx    = rnd_reg();
                rd_dx    = rnd_reg();
            end
            MD_resultRDY = m_waiting && u_act && (u_cnt == 0);
            MD_result    = $urandom();
            MD_exception = MD_resultRDY && ($urandom_range(0, 3) == 0);
            ctrl_writeReg_mdc = m_rd;
            wb_we   = ($urandom_range(0, 1) == 1);
            wb_reg  = 5'($urandom_range(0, 31));
            wb_data = $urandom();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
